comm_mode_switch_ctrl: RTL and testbench

Safe mode controller that drives the `sw_mode` select of the bus1↔bus2 / bus1↔bus3 serial route-through switch. It accepts a mode-change request over a valid/ready handshake. It changes `sw_mode` only after all three serial receive lines have been idle-high for a full quiet window, so no UART frame is ever cut mid-character. It sits between the host command logic and the route-through switch.

---
 rtl/comm_mode_pkg.sv | 14 +
 rtl/comm_mode_switch_ctrl_if.sv | 29 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/comm_mode_switch_ctrl.sv | 115 +++++++++++
 tb/tb_comm_mode_switch_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/comm_mode_pkg.sv
// Shared types and constants for the serial route-through mode controller.
package comm_mode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_QUIET,
        ST_SWITCH,
        ST_GUARD
    } state_t;

    localparam logic MODE_1_2 = 1'b0;
    localparam logic MODE_1_3 = 1'b1;

endpackage

// File: rtl/comm_mode_switch_ctrl_if.sv
// Mode-change request handshake and status between host logic and the controller.
interface comm_mode_switch_ctrl_if;

    logic req_valid;
    logic req_mode;
    logic req_ready;
    logic busy;
    logic done;
    logic err;

    modport master (
        output req_valid,
        output req_mode,
        input  req_ready,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req_mode,
        output req_ready,
        output busy,
        output done,
        output err
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an idle-high asynchronous line; resets to 1.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/comm_mode_switch_ctrl.sv
// Switches the route-through select only after all rx lines have been idle for a
// full frame time, so no UART character is ever cut in half.
module comm_mode_switch_ctrl
    import comm_mode_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES  = 8680,
    parameter int unsigned MAX_WAIT     = 1_000_000,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter logic        INIT_MODE    = MODE_1_2,
    parameter int unsigned CNT_W        = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    comm_mode_switch_ctrl_if.slave req,
    input  logic                   bus1_rx,
    input  logic                   bus2_rx,
    input  logic                   bus3_rx,
    output logic                   sw_mode
);

    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    logic             rx1_s;
    logic             rx2_s;
    logic             rx3_s;
    logic             idle;
    state_t           state;
    logic             target;
    logic [CNT_W-1:0] quiet_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    sync_2ff u_sync1 (.clk(clk), .rst_n(reset_n), .d(bus1_rx), .q(rx1_s));
    sync_2ff u_sync2 (.clk(clk), .rst_n(reset_n), .d(bus2_rx), .q(rx2_s));
    sync_2ff u_sync3 (.clk(clk), .rst_n(reset_n), .d(bus3_rx), .q(rx3_s));

    assign idle = rx1_s & rx2_s & rx3_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // wait_cnt doubles as the guard counter once the quiet wait is over
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            target    <= INIT_MODE;
            sw_mode   <= INIT_MODE;
            quiet_cnt <= '0;
            wait_cnt  <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req.req_valid && ready_r) begin
                        target <= req.req_mode;
                        if (req.req_mode == sw_mode) begin
                            done_r <= 1'b1;
                        end else begin
                            quiet_cnt <= '0;
                            wait_cnt  <= '0;
                            ready_r   <= 1'b0;
                            busy_r    <= 1'b1;
                            state     <= ST_WAIT_QUIET;
                        end
                    end
                end
                ST_WAIT_QUIET: begin
                    quiet_cnt <= idle ? sat_inc(quiet_cnt) : '0;
                    wait_cnt  <= sat_inc(wait_cnt);
                    if (idle && quiet_cnt == QUIET_LAST) begin
                        state <= ST_SWITCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err_r   <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_SWITCH: begin
                    sw_mode  <= target;
                    wait_cnt <= '0;
                    state    <= ST_GUARD;
                end
                ST_GUARD: begin
                    if (wait_cnt == GUARD_LAST) begin
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req.req_ready = ready_r;
    assign req.busy      = busy_r;
    assign req.done      = done_r;
    assign req.err       = err_r;

endmodule

// File: tb/tb_comm_mode_switch_ctrl.sv
// Directed bench for comm_mode_switch_ctrl with a cycle-level reference model.
module tb_comm_mode_switch_ctrl;

    localparam int unsigned IDLE  = 8;
    localparam int unsigned MAXW  = 32;
    localparam int unsigned GUARD = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic b1 = 1'b1;
    logic b2 = 1'b1;
    logic b3 = 1'b1;
    logic sw_mode;
    bit   chk_en = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    comm_mode_switch_ctrl_if bus ();

    comm_mode_switch_ctrl #(
        .IDLE_CYCLES (IDLE),
        .MAX_WAIT    (MAXW),
        .GUARD_CYCLES(GUARD),
        .INIT_MODE   (1'b0),
        .CNT_W       (20)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (bus),
        .bus1_rx(b1),
        .bus2_rx(b2),
        .bus3_rx(b3),
        .sw_mode(sw_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference model: tracks the request as elapsed cycles since acceptance and
    // a run length of idle samples seen through a two-sample delay.
    logic m_sw = 1'b0, m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    bit   m_active = 1'b0;
    logic m_target = 1'b0;
    int   m_elapsed = 0, m_quiet = 0, m_sw_at = -1;
    logic [1:0] raw_hist = 2'b11;

    initial forever begin
        logic seen_idle;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_sw = 1'b0; m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_active = 1'b0; raw_hist = 2'b11;
        end else begin
            seen_idle = raw_hist[1];
            raw_hist  = {raw_hist[0], b1 & b2 & b3};
            m_done = 1'b0;
            m_err  = 1'b0;
            if (!m_active) begin
                if (bus.req_valid) begin
                    if (bus.req_mode == m_sw) m_done = 1'b1;
                    else begin
                        m_active = 1'b1; m_target = bus.req_mode;
                        m_elapsed = 0; m_quiet = 0; m_sw_at = -1;
                    end
                end
            end else if (m_sw_at < 0) begin
                m_elapsed++;
                m_quiet = seen_idle ? m_quiet + 1 : 0;
                if (m_quiet == int'(IDLE)) m_sw_at = m_elapsed;
                else if (m_elapsed == int'(MAXW)) begin m_err = 1'b1; m_active = 1'b0; end
            end else begin
                m_elapsed++;
                if (m_elapsed == m_sw_at + 1) m_sw = m_target;
                if (m_elapsed == m_sw_at + 1 + int'(GUARD)) begin m_done = 1'b1; m_active = 1'b0; end
            end
            m_ready = !m_active;
            m_busy  = m_active;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en)
            check("cycle", {sw_mode, bus.req_ready, bus.busy, bus.done, bus.err},
                  {m_sw, m_ready, m_busy, m_done, m_err});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic request(input logic mode);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_mode  = mode;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int hits;
        bus.req_valid = 1'b0;
        bus.req_mode  = 1'b0;
        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        step(3);
        check("reset_outputs", {sw_mode, bus.req_ready, bus.busy, bus.done, bus.err}, 5'b01000);
        reset_n = 1'b1;
        step(1);
        check("after_release", {sw_mode, bus.req_ready, bus.busy, bus.done, bus.err}, 5'b01000);

        // basic switch to mode 1
        request(1'b1);
        check("accept_busy", {3'b0, bus.req_ready, bus.busy}, 5'b00001);
        step(8);
        check("sw_before_T9", {4'b0, sw_mode}, 5'd0);
        step(1);
        check("sw_at_T9", {4'b0, sw_mode}, 5'd1);
        step(3);
        check("no_done_T12", {4'b0, bus.done}, 5'd0);
        step(1);
        check("done_T13", {3'b0, bus.done, bus.req_ready}, 5'b00011);
        step(1);
        check("done_one_cycle", {4'b0, bus.done}, 5'd0);

        // bus3 activity restarts the quiet window
        request(1'b0);
        step(3);
        b3 = 1'b0;
        step(3);
        b3 = 1'b1;
        step(10);
        check("sw_held_T16", {4'b0, sw_mode}, 5'd1);
        step(1);
        check("sw_at_T17", {4'b0, sw_mode}, 5'd0);
        step(4);
        check("done_T21", {4'b0, bus.done}, 5'd1);

        // periodic bus2 activity forces a timeout
        request(1'b1);
        for (int i = 1; i <= 33; i++) begin
            step(1);
            if (i == 31) check("no_err_T31", {4'b0, bus.err}, 5'd0);
            if (i == 32) check("err_T32", {3'b0, bus.err, sw_mode}, 5'b00010);
            if (i == 33) check("err_one_cycle", {3'b0, bus.err, bus.req_ready}, 5'b00001);
            b2 = ((i % 5) != 4);
        end
        b2 = 1'b1;
        step(2);

        // same-mode request completes immediately
        request(1'b0);
        check("same_mode_done", {2'b0, bus.done, bus.busy, bus.req_ready}, 5'b00101);
        step(1);
        check("same_mode_pulse", {4'b0, bus.done}, 5'd0);

        // request during guard is dropped
        request(1'b1);
        step(11);
        bus.req_valid = 1'b1;
        bus.req_mode  = 1'b0;
        step(1);
        bus.req_valid = 1'b0;
        check("guard_not_ready", {4'b0, bus.req_ready}, 5'd0);
        step(1);
        check("guard_done", {4'b0, bus.done}, 5'd1);
        step(1);
        check("guard_idle", {2'b0, bus.done, bus.busy, bus.req_ready}, 5'b00001);
        step(3);
        check("guard_no_second", {3'b0, bus.done, sw_mode}, 5'b00001);

        // asynchronous reset during the quiet wait
        request(1'b0);
        step(4);
        #2 reset_n = 1'b0;
        #1 check("async_reset", {2'b0, sw_mode, bus.req_ready, bus.busy}, 5'b00010);
        step(2);
        reset_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (bus.done || bus.err) hits++;
        end
        check("no_pulse_after_reset", 5'(hits), 5'd0);
        check("mode_after_reset", {4'b0, sw_mode}, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
